// File: rtl/datalock_scoreboard_pkg.sv
// Shared types and constants for the data-lock scoreboard.
// common : architectural register address type.
// pipes  : lock counter width and default port counts.
package common;
   localparam int CREG_ADDR_W = 5;
   localparam int NUM_CREGS   = 32;
   typedef logic [CREG_ADDR_W-1:0] creg_addr_t;
endpackage

package pipes;
   localparam int LOCK_CNT_W       = 3;
   typedef logic [LOCK_CNT_W-1:0] lock_cnt_t;
   localparam int AREG_WRITE_PORTS = 2;
   localparam int AREG_READ_PORTS  = 2;
endpackage

// File: rtl/datalock_scoreboard_if.sv
// Issue/writeback-facing bundle of the data-lock scoreboard.
// master: issue + writeback side; slave: the scoreboard.
interface datalock_scoreboard_if
   import common::*, pipes::*;
#(
   parameter int ALLOC_PORTS   = AREG_WRITE_PORTS,
   parameter int RELEASE_PORTS = AREG_WRITE_PORTS,
   parameter int QUERY_PORTS   = AREG_READ_PORTS
);
   logic [ALLOC_PORTS-1:0]   alloc_valid;
   creg_addr_t               alloc_addr [ALLOC_PORTS];
   logic [RELEASE_PORTS-1:0] rel_valid;
   creg_addr_t               rel_addr [RELEASE_PORTS];
   logic                     flush;
   creg_addr_t               q_ra1 [QUERY_PORTS];
   creg_addr_t               q_ra2 [QUERY_PORTS];
   logic [QUERY_PORTS-1:0]   q_busy1;
   logic [QUERY_PORTS-1:0]   q_busy2;
   logic                     idle;
   logic                     err;

   modport master (
      output alloc_valid, alloc_addr, rel_valid, rel_addr, flush, q_ra1, q_ra2,
      input  q_busy1, q_busy2, idle, err
   );

   modport slave (
      input  alloc_valid, alloc_addr, rel_valid, rel_addr, flush, q_ra1, q_ra2,
      output q_busy1, q_busy2, idle, err
   );
endinterface

// File: rtl/datalock_scoreboard_lock_counter.sv
// One saturating up/down lock counter for a single architectural register.
// sat_err pulses in any cycle whose net update leaves the counter range.
module lock_counter
   import pipes::*;
#(
   parameter int CNT_W  = LOCK_CNT_W,
   parameter int PCNT_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic [PCNT_W-1:0] inc,
   input  logic [PCNT_W-1:0] dec,
   output logic [CNT_W-1:0]  cnt,
   output logic              zero,
   output logic              sat_err
);
   localparam int SUM_W = CNT_W + 2;
   localparam logic signed [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

   logic signed [SUM_W-1:0] sum;

   function automatic logic out_of_range(input logic signed [SUM_W-1:0] v);
      return v[SUM_W-1] || (v > CNT_MAX);
   endfunction

   function automatic logic [CNT_W-1:0] sat_clamp(input logic signed [SUM_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v[SUM_W-1])
         r = '0;
      else if (v > CNT_MAX)
         r = '1;
      else
         r = v[CNT_W-1:0];
      return r;
   endfunction

   assign sum = $signed({2'b00, cnt}) + $signed(SUM_W'(inc)) - $signed(SUM_W'(dec));

   // counter register: flush wins over traffic, reset wins over everything
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (flush)
         cnt <= '0;
      else
         cnt <= sat_clamp(sum);
   end

   // range violation is suppressed in a flush cycle since the update is discarded
   always_comb begin
      sat_err = !flush && out_of_range(sum);
      zero    = (cnt == '0);
   end
endmodule

// File: rtl/datalock_scoreboard.sv
// Per-register pending-write scoreboard for the issue stage.
// Optional macro SCOREBOARD_BYPASS_EN: same-cycle releases are subtracted
// on the query path so a dependent source is freed in the release cycle.
module datalock_scoreboard
   import common::*, pipes::*;
#(
   parameter int ALLOC_PORTS   = AREG_WRITE_PORTS,
   parameter int RELEASE_PORTS = AREG_WRITE_PORTS,
   parameter int QUERY_PORTS   = AREG_READ_PORTS,
   parameter int CNT_W         = LOCK_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   datalock_scoreboard_if.slave sb
);
   localparam int NREG   = NUM_CREGS;
   localparam int MAXP   = (ALLOC_PORTS > RELEASE_PORTS) ? ALLOC_PORTS : RELEASE_PORTS;
   localparam int PCNT_W = $clog2(MAXP + 1);
   localparam int SUM_W  = CNT_W + 2;

   logic [PCNT_W-1:0] inc [NREG];
   logic [PCNT_W-1:0] dec [NREG];
   logic [CNT_W-1:0]  cnt [NREG];
   logic [NREG-1:1]   zero;
   logic [NREG-1:1]   sat_err;
   logic              err_q;

   // x0 is never locked
   assign cnt[0] = '0;

   // address decode: count how many ports hit each register this cycle
   always_comb begin
      inc[0] = '0;
      dec[0] = '0;
      for (int i = 1; i < NREG; i++) begin
         inc[i] = '0;
         dec[i] = '0;
         for (int p = 0; p < ALLOC_PORTS; p++)
            if (sb.alloc_valid[p] && (sb.alloc_addr[p] == CREG_ADDR_W'(i)))
               inc[i] = inc[i] + PCNT_W'(1);
         for (int p = 0; p < RELEASE_PORTS; p++)
            if (sb.rel_valid[p] && (sb.rel_addr[p] == CREG_ADDR_W'(i)))
               dec[i] = dec[i] + PCNT_W'(1);
      end
   end

   for (genvar i = 1; i < NREG; i++) begin : g_cnt
      lock_counter #(
         .CNT_W  (CNT_W),
         .PCNT_W (PCNT_W)
      ) u_cnt (
         .clk     (clk),
         .reset   (reset),
         .flush   (sb.flush),
         .inc     (inc[i]),
         .dec     (dec[i]),
         .cnt     (cnt[i]),
         .zero    (zero[i]),
         .sat_err (sat_err[i])
      );
   end

   function automatic logic src_busy(input creg_addr_t a);
`ifdef SCOREBOARD_BYPASS_EN
      // a release arriving this cycle already frees its share of the count
      return SUM_W'(cnt[a]) > SUM_W'(dec[a]);
`else
      return cnt[a] != '0;
`endif
   endfunction

   // source-operand query muxes, combinational off the counters
   always_comb begin
      sb.q_busy1 = '0;
      sb.q_busy2 = '0;
      for (int k = 0; k < QUERY_PORTS; k++) begin
         sb.q_busy1[k] = src_busy(sb.q_ra1[k]);
         sb.q_busy2[k] = src_busy(sb.q_ra2[k]);
      end
   end

   // sticky error: any counter saturation sets it until reset
   always_ff @(posedge clk) begin
      if (reset)
         err_q <= 1'b0;
      else if (|sat_err)
         err_q <= 1'b1;
   end

   assign sb.idle = &zero;
   assign sb.err  = err_q;
endmodule

// File: tb/tb_datalock_scoreboard.sv
// Directed bench for datalock_scoreboard; honours SCOREBOARD_BYPASS_EN.
module tb_datalock_scoreboard;
   import common::*, pipes::*;

`ifdef SCOREBOARD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   datalock_scoreboard_if sbif ();

   datalock_scoreboard dut (
      .clk   (clk),
      .reset (reset),
      .sb    (sbif.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr();
      sbif.alloc_valid = '0;
      sbif.rel_valid   = '0;
      sbif.flush       = 1'b0;
      for (int p = 0; p < 2; p++) begin
         sbif.alloc_addr[p] = '0;
         sbif.rel_addr[p]   = '0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // advance one edge, drop requests, let the query path settle
   task automatic step();
      cyc();
      clr();
      #1;
   endtask

   task automatic alloc(input int port, input int addr);
      sbif.alloc_valid[port] = 1'b1;
      sbif.alloc_addr[port]  = CREG_ADDR_W'(addr);
   endtask

   task automatic rel(input int port, input int addr);
      sbif.rel_valid[port] = 1'b1;
      sbif.rel_addr[port]  = CREG_ADDR_W'(addr);
   endtask

   initial begin
      clr();
      for (int k = 0; k < 2; k++) begin
         sbif.q_ra1[k] = '0;
         sbif.q_ra2[k] = '0;
      end
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;

      // reset state
      sbif.q_ra1[0] = 5'd5;
      sbif.q_ra2[0] = 5'd6;
      #1;
      chk("rst_busy_r5", sbif.q_busy1[0], 0);
      chk("rst_busy_r6", sbif.q_busy2[0], 0);
      chk("rst_idle", sbif.idle, 1);
      chk("rst_err", sbif.err, 0);

      // alloc r5 at t, release at t+3
      alloc(0, 5);
      #1;
      chk("alloc_r5_t", sbif.q_busy1[0], 0);
      step();
      chk("alloc_r5_t1", sbif.q_busy1[0], 1);
      chk("alloc_r5_idle", sbif.idle, 0);
      cyc();
      cyc();
      rel(0, 5);
      #1;
      chk("rel_r5_t3", sbif.q_busy1[0], BYP ? 0 : 1);
      step();
      chk("rel_r5_t4", sbif.q_busy1[0], 0);
      chk("rel_r5_idle", sbif.idle, 1);

      // both alloc ports on r7
      sbif.q_ra1[1] = 5'd7;
      alloc(0, 7);
      alloc(1, 7);
      step();
      chk("r7_cnt2_busy", sbif.q_busy1[1], 1);
      rel(1, 7);
      step();
      chk("r7_cnt1_busy", sbif.q_busy1[1], 1);
      rel(0, 7);
      step();
      chk("r7_free", sbif.q_busy1[1], 0);
      chk("r7_idle", sbif.idle, 1);

      // same-cycle alloc and release on r9 net out
      sbif.q_ra2[1] = 5'd9;
      alloc(0, 9);
      step();
      chk("r9_busy", sbif.q_busy2[1], 1);
      alloc(0, 9);
      rel(1, 9);
      #1;
      chk("r9_net_same_cyc", sbif.q_busy2[1], BYP ? 0 : 1);
      step();
      chk("r9_net_busy", sbif.q_busy2[1], 1);
      chk("r9_net_err", sbif.err, 0);
      rel(0, 9);
      step();
      chk("r9_free", sbif.q_busy2[1], 0);
      chk("r9_idle", sbif.idle, 1);

      // saturation on r3
      sbif.q_ra1[0] = 5'd3;
      for (int n = 0; n < 7; n++) begin
         alloc(0, 3);
         step();
      end
      chk("r3_at7_err", sbif.err, 0);
      alloc(0, 3);
      #1;
      chk("r3_8th_err_same", sbif.err, 0);
      step();
      chk("r3_ovf_err", sbif.err, 1);
      chk("r3_ovf_busy", sbif.q_busy1[0], 1);
      for (int n = 0; n < 6; n++) begin
         rel(0, 3);
         step();
      end
      chk("r3_cnt1_busy", sbif.q_busy1[0], 1);
      rel(0, 3);
      step();
      chk("r3_cnt0_busy", sbif.q_busy1[0], 0);
      chk("r3_cnt0_idle", sbif.idle, 1);
      rel(0, 3);
      step();
      chk("r3_udf_busy", sbif.q_busy1[0], 0);
      chk("r3_udf_idle", sbif.idle, 1);
      chk("r3_udf_err", sbif.err, 1);

      // lock r1, r2, r31 then flush with a same-cycle alloc to r4
      sbif.q_ra1[0] = 5'd1;
      sbif.q_ra2[0] = 5'd2;
      sbif.q_ra1[1] = 5'd31;
      sbif.q_ra2[1] = 5'd4;
      alloc(0, 1);
      alloc(1, 2);
      step();
      alloc(0, 31);
      step();
      chk("lk_r1", sbif.q_busy1[0], 1);
      chk("lk_r2", sbif.q_busy2[0], 1);
      chk("lk_r31", sbif.q_busy1[1], 1);
      chk("lk_idle", sbif.idle, 0);
      sbif.flush = 1'b1;
      alloc(0, 4);
      step();
      chk("fl_r1", sbif.q_busy1[0], 0);
      chk("fl_r2", sbif.q_busy2[0], 0);
      chk("fl_r31", sbif.q_busy1[1], 0);
      chk("fl_r4", sbif.q_busy2[1], 0);
      chk("fl_idle", sbif.idle, 1);
      chk("fl_err_sticky", sbif.err, 1);

      // x0 is never locked
      sbif.q_ra1[0] = 5'd0;
      alloc(0, 0);
      alloc(1, 0);
      step();
      chk("r0_busy", sbif.q_busy1[0], 0);
      chk("r0_idle", sbif.idle, 1);

      // reset clears err; flush suppresses underflow error
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst2_err", sbif.err, 0);
      sbif.flush = 1'b1;
      rel(0, 10);
      step();
      chk("fl_udf_err", sbif.err, 0);
      rel(1, 10);
      step();
      chk("udf_r10_err", sbif.err, 1);
      chk("udf_r10_idle", sbif.idle, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
